// File: rtl/avalon_onchip_ram_ctrl_if.sv
// Avalon-MM slave bus bundle for the on-chip RAM controller.
// Collects the request, write data and read response signals of one
// Avalon-MM port. The master modport drives requests, and the slave modport
// returns data and back-pressure.
interface avalon_onchip_ram_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    modport master (
        output address,
        output byteenable,
        output chipselect,
        output read,
        output write,
        output writedata,
        input  readdata,
        input  readdatavalid,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  byteenable,
        input  chipselect,
        input  read,
        input  write,
        input  writedata,
        output readdata,
        output readdatavalid,
        output waitrequest
    );
endinterface

// File: rtl/avalon_onchip_ram_ctrl.sv
// Parametrised Avalon-MM single-port on-chip RAM slave.
// - Byte-enabled writes go to an inferred RAM array.
// - The read path has a latency of 1 or 2 and a readdatavalid strobe.
// - The zeroise engine fills every word with CLEAR_VALUE after reset or on
//   clear_req. It holds waitrequest high while it runs, so software never
//   sees stale contents.
// - The effective enable (clken & ~reset_req) freezes all state.
module avalon_onchip_ram_ctrl #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 12,
    parameter int                    DEPTH          = 4096,
    parameter int                    READ_LATENCY   = 1,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clken,
    input  logic                      reset_req,
    input  logic                      clear_req,
    output logic                      clear_busy,
    avalon_onchip_ram_ctrl_if.slave   bus
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    // One extra bit, so that DEPTH == 2**ADDR_WIDTH is reachable without wrap.
    localparam int CNT_W     = ADDR_WIDTH + 1;

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    // Effective enable and Avalon handshake decode
    logic                  en_s;
    logic                  waitrequest_s;
    logic                  addr_in_range_s;
    logic                  wr_accept_s;
    logic                  rd_accept_s;

    // Clear engine FSM
    state_t                state_r;
    state_t                state_nxt_s;
    logic [CNT_W-1:0]      clr_cnt_r;
    logic [CNT_W-1:0]      clr_cnt_nxt_s;
    logic                  clear_busy_r;

    // RAM write port (shared by the clear engine and Avalon writes)
    logic                  ram_we_s;
    logic [ADDR_WIDTH-1:0] ram_addr_s;
    logic [DATA_WIDTH-1:0] ram_wdata_s;
    logic [NUM_BYTES-1:0]  ram_be_s;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Read pipeline, first stage
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic                  rd_valid1_r;
    logic [DATA_WIDTH-1:0] rd_data1_r;

    // Decode the effective enable, back-pressure and request acceptance
    always_comb begin
        en_s            = clken & ~reset_req;
        waitrequest_s   = reset | (state_r == ST_CLEAR) | ~en_s;
        addr_in_range_s = ({1'b0, bus.address} < DEPTH_CNT);
        wr_accept_s     = bus.chipselect & bus.write & ~waitrequest_s;
        rd_accept_s     = bus.chipselect & bus.read & ~bus.write & ~waitrequest_s;
    end

    assign bus.waitrequest = waitrequest_s;
    assign clear_busy      = clear_busy_r;

    // Next state and clear counter. A clear walks the words 0..DEPTH-1 once.
    always_comb begin
        state_nxt_s   = state_r;
        clr_cnt_nxt_s = clr_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (clear_req) begin
                    state_nxt_s   = ST_CLEAR;
                    clr_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_r == LAST_CNT) begin
                    state_nxt_s   = ST_IDLE;
                    clr_cnt_nxt_s = '0;
                end else begin
                    clr_cnt_nxt_s = clr_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                clr_cnt_nxt_s = '0;
            end
        endcase
    end

    // Hold the FSM state, the clear counter and the registered busy flag.
    // Everything freezes while en is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= RESET_STATE;
            clr_cnt_r    <= '0;
            clear_busy_r <= (RESET_STATE == ST_CLEAR);
        end else if (en_s) begin
            state_r      <= state_nxt_s;
            clr_cnt_r    <= clr_cnt_nxt_s;
            clear_busy_r <= (state_nxt_s == ST_CLEAR);
        end
    end

    // Choose the RAM write source. The clear engine owns the port while it
    // runs, because waitrequest blocks Avalon writes in that state.
    always_comb begin
        if (state_r == ST_CLEAR) begin
            ram_we_s    = en_s;
            ram_addr_s  = clr_cnt_r[ADDR_WIDTH-1:0];
            ram_wdata_s = CLEAR_VALUE;
            ram_be_s    = {NUM_BYTES{1'b1}};
        end else begin
            ram_we_s    = wr_accept_s & addr_in_range_s;
            ram_addr_s  = bus.address;
            ram_wdata_s = bus.writedata;
            ram_be_s    = bus.byteenable;
        end
    end

    // Byte-enabled RAM write. Out-of-range addresses never reach this port.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (ram_be_s[b]) begin
                    mem_r[ram_addr_s][8*b +: 8] <= ram_wdata_s[8*b +: 8];
                end
            end
        end
    end

    // Read lookup. An out-of-range address reads as zero.
    always_comb begin
        if (addr_in_range_s) begin
            rd_word_s = mem_r[bus.address];
        end else begin
            rd_word_s = '0;
        end
    end

    // First read stage: capture the word at the accept edge, and keep
    // readdata stable between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid1_r <= 1'b0;
            rd_data1_r  <= '0;
        end else if (en_s) begin
            rd_valid1_r <= rd_accept_s;
            if (rd_accept_s) begin
                rd_data1_r <= rd_word_s;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  rd_valid2_r;
            logic [DATA_WIDTH-1:0] rd_data2_r;

            // Second read stage: an extra output register for timing closure
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_valid2_r <= 1'b0;
                    rd_data2_r  <= '0;
                end else if (en_s) begin
                    rd_valid2_r <= rd_valid1_r;
                    if (rd_valid1_r) begin
                        rd_data2_r <= rd_data1_r;
                    end
                end
            end

            assign bus.readdata      = rd_data2_r;
            assign bus.readdatavalid = rd_valid2_r;
        end else begin : g_lat1
            assign bus.readdata      = rd_data1_r;
            assign bus.readdatavalid = rd_valid1_r;
        end
    endgenerate

endmodule

// File: tb/tb_avalon_onchip_ram_ctrl.sv
// Scoreboard bench for avalon_onchip_ram_ctrl.
// - Two instances share the same stimulus:
//   - dut1 has latency 1 and CLEAR_VALUE 0.
//   - dut2 has latency 2 and CLEAR_VALUE 0x12345678.
// - Each read pushes its expected data into a queue, along with the
//   en-cycle count at which its readdatavalid must appear.
// - Monitors pop each queue on every fresh readdatavalid.
module tb_avalon_onchip_ram_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 16;
    localparam logic [31:0] CV2 = 32'h1234_5678;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          clken;
    logic          reset_req;
    logic          clear_req;
    logic [AW-1:0] address;
    logic [3:0]    byteenable;
    logic          chipselect;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic          clear_busy1;
    logic          clear_busy2;

    avalon_onchip_ram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
    avalon_onchip_ram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

    assign bus1.address    = address;
    assign bus1.byteenable = byteenable;
    assign bus1.chipselect = chipselect;
    assign bus1.read       = read;
    assign bus1.write      = write;
    assign bus1.writedata  = writedata;
    assign bus2.address    = address;
    assign bus2.byteenable = byteenable;
    assign bus2.chipselect = chipselect;
    assign bus2.read       = read;
    assign bus2.write      = write;
    assign bus2.writedata  = writedata;

    avalon_onchip_ram_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(1),
        .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0000_0000)
    ) dut1 (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .clear_req(clear_req), .clear_busy(clear_busy1), .bus(bus1)
    );

    avalon_onchip_ram_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(2),
        .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV2)
    ) dut2 (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .clear_req(clear_req), .clear_busy(clear_busy2), .bus(bus2)
    );

    int   checks = 0;
    int   errors = 0;
    int   en_cnt = 0;
    logic last_en = 1'b0;
    exp_t q1[$];
    exp_t q2[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Count enabled clock edges; this is the time base for read latency.
    always @(posedge clk) begin
        last_en <= clken && !reset_req && !reset;
        if (clken && !reset_req && !reset) en_cnt <= en_cnt + 1;
    end

    // dut1 monitor: count a valid only once, at the first negedge after an
    // enabled edge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && last_en && bus1.readdatavalid) begin
            if (q1.size() == 0) begin
                check("rd1_unexpected_valid", 32'(bus1.readdatavalid), 32'd0);
            end else begin
                e = q1.pop_front();
                check("rd1_data", bus1.readdata, e.data);
                check("rd1_cycle", en_cnt, e.due);
            end
        end
    end

    // dut2 monitor (latency 2)
    always @(negedge clk) begin
        exp_t e;
        if (!reset && last_en && bus2.readdatavalid) begin
            if (q2.size() == 0) begin
                check("rd2_unexpected_valid", 32'(bus2.readdatavalid), 32'd0);
            end else begin
                e = q2.pop_front();
                check("rd2_data", bus2.readdata, e.data);
                check("rd2_cycle", en_cnt, e.due);
            end
        end
    end

    task automatic rd(input logic [AW-1:0] a, input logic [31:0] e1, input logic [31:0] e2);
        address = a; chipselect = 1'b1; read = 1'b1; write = 1'b0;
        @(posedge clk); #1;
        q1.push_back('{data: e1, due: en_cnt});
        q2.push_back('{data: e2, due: en_cnt + 1});
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        address = a; writedata = d; byteenable = be;
        chipselect = 1'b1; write = 1'b1; read = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Count the sampled cycles with clear_busy high, starting at a negedge.
    // Optionally freeze for 3 cycles at freeze_at (through reset_req or
    // clken), and/or pulse clear_req at req_at.
    task automatic measure(input int freeze_at, input int req_at, input bit use_rr,
                           output int n1, output int n2);
        bit frz;
        n1 = 0; n2 = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (!clear_busy1 && !clear_busy2) break;
            n1 += int'(clear_busy1);
            n2 += int'(clear_busy2);
            frz = (i >= freeze_at) && (i < freeze_at + 3);
            if (use_rr) reset_req = frz; else clken = !frz;
            clear_req = (i == req_at);
            @(negedge clk);
        end
        clken = 1'b1; reset_req = 1'b0; clear_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n1, n2;
        reset = 1'b1; clken = 1'b1; reset_req = 1'b0; clear_req = 1'b0;
        address = '0; byteenable = 4'hF; chipselect = 1'b0; read = 1'b0;
        write = 1'b0; writedata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_readdata1", bus1.readdata, 32'h0);
        check("rst_rdvalid1", 32'(bus1.readdatavalid), 32'd0);
        check("rst_waitreq1", 32'(bus1.waitrequest), 32'd1);
        check("rst_busy1", 32'(clear_busy1), 32'd1);
        check("rst_readdata2", bus2.readdata, 32'h0);
        check("rst_busy2", 32'(clear_busy2), 32'd1);

        // 1: clear after reset release lasts exactly DEPTH cycles
        @(negedge clk); reset = 1'b0;
        measure(-10, -10, 1'b0, n1, n2);
        check("t1_clear_len1", n1, 32'd16);
        check("t1_clear_len2", n2, 32'd16);
        check("t1_waitreq_after", 32'(bus1.waitrequest), 32'd0);
        for (int i = 0; i < DEPTH; i++) rd(AW'(i), 32'h0, CV2);
        idle(4);

        // 2: byte-enabled merge, read right after write
        wr(5'd5, 32'hDEAD_BEEF, 4'b1111);
        wr(5'd5, 32'h0000_00AA, 4'b0001);
        rd(5'd5, 32'hDEAD_BEAA, 32'hDEAD_BEAA);
        idle(4);

        // 3: back-to-back reads without bubbles
        for (int i = 0; i < 4; i++) wr(AW'(i), 32'h10 + 32'(i), 4'hF);
        for (int i = 0; i < 4; i++) rd(AW'(i), 32'h10 + 32'(i), 32'h10 + 32'(i));
        idle(4);

        // 4a: clken low for 3 cycles right after a read is accepted
        rd(5'd1, 32'h11, 32'h11);
        chipselect = 1'b0; read = 1'b0; clken = 1'b0;
        #1;
        check("t4_waitreq_frozen", 32'(bus1.waitrequest), 32'd1);
        repeat (3) @(posedge clk);
        #1; clken = 1'b1;
        idle(4);

        // 4b: reset_req freezes a clear for 3 cycles
        clear_req = 1'b1;
        @(posedge clk); #1; clear_req = 1'b0;
        @(negedge clk);
        measure(4, -10, 1'b1, n1, n2);
        check("t4_clear_len1", n1, 32'd19);
        check("t4_clear_len2", n2, 32'd19);

        // 5: fill, then start a clear in the same cycle as a read is accepted
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), 32'hFFFF_FFFF, 4'hF);
        clear_req = 1'b1;
        rd(5'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        clear_req = 1'b0; chipselect = 1'b0; read = 1'b0;
        @(negedge clk);
        measure(-10, 8, 1'b0, n1, n2);
        check("t5_clear_len1", n1, 32'd16);
        check("t5_clear_len2", n2, 32'd16);
        for (int i = 0; i < DEPTH; i++) rd(AW'(i), 32'h0, CV2);
        idle(4);

        // 6: out-of-range read and write
        rd(5'd16, 32'h0, 32'h0);
        wr(5'd16, 32'hCAFE_F00D, 4'hF);
        rd(5'd0, 32'h0, CV2);
        idle(4);

        // 6b: reset right after a read is accepted loses that read
        address = 5'd2; chipselect = 1'b1; read = 1'b1; write = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; chipselect = 1'b0; read = 1'b0;
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        measure(-10, -10, 1'b0, n1, n2);
        check("t6_reset_clear_len1", n1, 32'd16);

        // 6c: reset in the middle of a clear restarts it from word 0
        clear_req = 1'b1;
        @(posedge clk); #1; clear_req = 1'b0;
        repeat (5) @(posedge clk);
        #1; reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        measure(-10, -10, 1'b0, n1, n2);
        check("t6_midclear_len1", n1, 32'd16);
        check("t6_midclear_len2", n2, 32'd16);
        rd(5'd0, 32'h0, CV2);
        idle(6);

        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
